// File: rtl/smc_pkg.sv
// Shared constants, encodings and helpers for the smc_stream selector/sum path.
//   IN_W   : width of the w/vgs/vds tuple fields
//   VT     : threshold subtracted from vgs (modulo 2^IN_W)
//   N_DEV  : devices per batch (3..8)
//   OUT_W  : result width (max 12*114 = 1368)
//   KEY_W  : width of an id/gm value and of one sort-array entry
package smc_pkg;

    localparam int IN_W  = 3;
    localparam int VT    = 1;
    localparam int N_DEV = 6;
    localparam int OUT_W = 11;
    localparam int KEY_W = 8;
    localparam int CNT_W = $clog2(N_DEV + 1);

    localparam logic [1:0] MODE_GM_LO = 2'b00;
    localparam logic [1:0] MODE_ID_LO = 2'b01;
    localparam logic [1:0] MODE_GM_HI = 2'b10;
    localparam logic [1:0] MODE_ID_HI = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    typedef struct packed {
        logic [IN_W-1:0] w;
        logic [IN_W-1:0] vgs;
        logic [IN_W-1:0] vds;
    } tuple_t;

    // Plain sum a+b+c, or 3a+4b+5c when weighted.
    function automatic logic [OUT_W-1:0] sum3(input logic [KEY_W-1:0] a,
                                              input logic [KEY_W-1:0] b,
                                              input logic [KEY_W-1:0] c,
                                              input logic             weighted);
        logic [OUT_W-1:0] r;
        if (weighted)
            r = OUT_W'(3) * OUT_W'(a) + OUT_W'(4) * OUT_W'(b) + OUT_W'(5) * OUT_W'(c);
        else
            r = OUT_W'(a) + OUT_W'(b) + OUT_W'(c);
        return r;
    endfunction

endpackage

// File: rtl/smc_device_eval.sv
// Combinational MOSFET evaluator: (w, vgs, vds) -> (id, gm).
//   w, vgs, vds : IN_W-bit device tuple
//   id, gm      : KEY_W-bit truncated quotients (divide by 3)
// Region: diff = vgs - VT (wraps); diff > vds is triode, else saturation.
module smc_device_eval
    import smc_pkg::*;
(
    input  logic [IN_W-1:0]  w,
    input  logic [IN_W-1:0]  vgs,
    input  logic [IN_W-1:0]  vds,
    output logic [KEY_W-1:0] id,
    output logic [KEY_W-1:0] gm
);

    // Wide enough for w*vds*(2*diff-vds) with no truncation.
    localparam int PW = 3 * IN_W + 2;

    logic [IN_W-1:0] diff;
    logic [PW-1:0]   id_num;
    logic [PW-1:0]   gm_num;

    always_comb begin
        diff = vgs - IN_W'(VT);
        if (diff > vds) begin
            id_num = PW'(w) * PW'(vds) * (PW'(2) * PW'(diff) - PW'(vds));
            gm_num = PW'(2) * PW'(w) * PW'(vds);
        end else begin
            id_num = PW'(w) * PW'(diff) * PW'(diff);
            gm_num = PW'(2) * PW'(w) * PW'(diff);
        end
    end

    assign id = KEY_W'(id_num / PW'(3));
    assign gm = KEY_W'(gm_num / PW'(3));

endmodule

// File: rtl/smc_stream.sv
// Streaming selector/sum front end.
// Accepts N_DEV tuples per batch, insertion-sorts id or gm into a descending
// array, then emits one (weighted) sum of the three largest or smallest keys.
//   clk, rst_n     : clock, async active-low reset
//   in_valid       : tuple (and mode on the first tuple) valid
//   mode           : 00 GM lo sum, 01 ID lo weighted, 10 GM hi sum, 11 ID hi weighted
//   w, vgs, vds    : device tuple
//   out_valid      : one-cycle result strobe
//   out_n          : result, zero whenever out_valid is low
module smc_stream
    import smc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  w,
    input  logic [IN_W-1:0]  vgs,
    input  logic [IN_W-1:0]  vds,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_n
);

    state_t                        state, state_nxt;
    logic [CNT_W-1:0]              count_q;
    logic [1:0]                    mode_q;
    logic [N_DEV-1:0][KEY_W-1:0]   sort_q, sort_nxt;
    logic [N_DEV-1:0]              ge;

    logic             accept, last, calc_en;
    logic [1:0]       mode_eff;
    tuple_t           tup;
    logic [KEY_W-1:0] id, gm, key;
    logic [OUT_W-1:0] sum;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = last ? CALC : LOAD;
            LOAD:    if (last)   state_nxt = CALC;
            CALC:    state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        accept  = in_valid && (state == IDLE || state == LOAD);
        last    = accept && (count_q == CNT_W'(N_DEV - 1));
        calc_en = (state == CALC);
    end

    // mode is live on the first tuple, registered for the rest of the batch.
    assign mode_eff = (state == IDLE) ? mode : mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            mode_q  <= MODE_GM_LO;
        end else if (accept) begin
            count_q <= last ? '0 : count_q + CNT_W'(1);
            if (state == IDLE) mode_q <= mode;
        end
    end

    // ---------------- evaluate + insertion sort ----------------
    assign tup = '{w: w, vgs: vgs, vds: vds};

    smc_device_eval u_eval (
        .w   (tup.w),
        .vgs (tup.vgs),
        .vds (tup.vds),
        .id  (id),
        .gm  (gm)
    );

    assign key = (mode_eff == MODE_GM_LO || mode_eff == MODE_GM_HI) ? gm : id;

    // ge[i]: slot i holds a live entry >= key. Array is descending, so ge is a
    // prefix of ones; the key lands right after the last equal entry (stable)
    // and everything below it shifts down one slot. Slots at or beyond
    // count_q hold stale data and are never compared, so no batch-start clear.
    for (genvar i = 0; i < N_DEV; i++) begin : g_slot
        assign ge[i] = (CNT_W'(i) < count_q) && (sort_q[i] >= key);
        if (i == 0) begin : g_head
            assign sort_nxt[i] = ge[i] ? sort_q[i] : key;
        end else begin : g_body
            assign sort_nxt[i] = ge[i]   ? sort_q[i]   :
                                 ge[i-1] ? key         : sort_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sort_q <= '0;
        else if (accept) sort_q <= sort_nxt;
    end

    // ---------------- result ----------------
    always_comb begin
        if (mode_q == MODE_GM_HI || mode_q == MODE_ID_HI)
            sum = sum3(sort_q[0], sort_q[1], sort_q[2],
                       mode_q == MODE_ID_HI);
        else
            sum = sum3(sort_q[N_DEV-3], sort_q[N_DEV-2], sort_q[N_DEV-1],
                       mode_q == MODE_ID_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_n     <= '0;
        end else if (calc_en) begin
            out_valid <= 1'b1;
            out_n     <= sum;
        end else begin
            out_valid <= 1'b0;
            out_n     <= '0;
        end
    end

endmodule

// File: tb/tb_smc_stream.sv
// Bench for smc_stream: table of uniform/ramped batches plus hand sequences
// for ignore rules, back-to-back batches and reset. Expected results go into
// a scoreboard queue with their due cycle; a negedge monitor pops them.
module tb_smc_stream;
    import smc_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [IN_W-1:0]  w = '0;
    logic [IN_W-1:0]  vgs = '0;
    logic [IN_W-1:0]  vds = '0;
    logic             out_valid;
    logic [OUT_W-1:0] out_n;

    smc_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .mode      (mode),
        .w         (w),
        .vgs       (vgs),
        .vds       (vds),
        .out_valid (out_valid),
        .out_n     (out_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OUT_W-1:0] val;
        int               due;
    } exp_t;

    typedef struct {
        logic [1:0]       mode;
        int               wb;
        int               ws;
        int               vg;
        int               vd;
        logic [OUT_W-1:0] exp;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one tuple for the cycle after the next posedge.
    task automatic send(input logic [1:0] m, input int wv, input int vg, input int vd,
                        input bit is_last, input logic [OUT_W-1:0] exp);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1;
        mode     = m;
        w        = IN_W'(wv);
        vgs      = IN_W'(vg);
        vds      = IN_W'(vd);
        if (is_last) begin
            e.val = exp;
            e.due = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            mode     = 2'($urandom);
            w        = IN_W'($urandom);
        end
    endtask

    task automatic batch(input vec_t v);
        for (int i = 0; i < N_DEV; i++)
            send(v.mode, v.wb + i * v.ws, v.vg, v.vd, i == N_DEV - 1, v.exp);
    endtask

    // Monitor: every strobe must match the queue head on its due cycle;
    // out_n must be zero when not strobing; an overdue head is a miss.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", int'(out_valid), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_n", int'(out_n), int'(mon_e.val));
                chk("latency_cycle", cyc, mon_e.due);
            end
        end else begin
            chk("idle_out_n_zero", int'(out_n), 0);
            if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("missing_out_valid", int'(out_valid), 1);
                void'(sb.pop_front());
            end
        end
    end

    vec_t vecs[8];

    initial begin
        // ramp W=1..6, VGS=3, VDS=3: gm = id = {1,2,4,5,6,8}
        vecs[0] = '{MODE_GM_HI, 1, 1, 3, 3, 11'd19};
        vecs[1] = '{MODE_ID_LO, 1, 1, 3, 3, 11'd25};
        vecs[2] = '{MODE_GM_LO, 1, 1, 3, 3, 11'd7};
        vecs[3] = '{MODE_ID_HI, 1, 1, 3, 3, 11'd73};
        // VGS=0 wraps to diff=7, id=114 -> 12*114
        vecs[4] = '{MODE_ID_HI, 7, 0, 0, 7, 11'd1368};
        // triode W=2, VGS=5, VDS=1: id=4, gm=1
        vecs[5] = '{MODE_ID_LO, 2, 0, 5, 1, 11'd48};
        vecs[6] = '{MODE_GM_LO, 2, 0, 5, 1, 11'd3};
        vecs[7] = '{MODE_GM_HI, 2, 0, 5, 1, 11'd3};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_n", int'(out_n), 0);
        rst_n = 1'b1;
        idle(2);

        for (int v = 0; v < 8; v++) begin
            batch(vecs[v]);
            idle(3);
        end

        // gaps, mode toggled after first tuple, in_valid held through CALC/OUT,
        // then next batch starts back-to-back in the following IDLE cycle.
        send(MODE_ID_LO, 1, 3, 3, 0, '0);
        idle(2);
        send(MODE_GM_HI, 2, 3, 3, 0, '0);
        idle(1);
        send(MODE_GM_LO, 3, 3, 3, 0, '0);
        send(MODE_ID_HI, 4, 3, 3, 0, '0);
        idle(1);
        send(MODE_GM_HI, 5, 3, 3, 0, '0);
        send(MODE_GM_HI, 6, 3, 3, 1, 11'd25);
        send(MODE_ID_HI, 7, 0, 7, 0, '0);   // CALC: ignored
        send(MODE_ID_HI, 7, 0, 7, 0, '0);   // OUT: ignored
        batch(vecs[0]);
        idle(4);

        // reset mid-batch with large keys; next batch must be unaffected
        for (int i = 0; i < 3; i++) send(MODE_ID_HI, 7, 0, 7, 0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midbatch_rst_out_valid", int'(out_valid), 0);
        chk("midbatch_rst_out_n", int'(out_n), 0);
        idle(2);
        rst_n = 1'b1;
        batch(vecs[0]);
        idle(4);

        // reset while the result strobe is high: both outputs clear at once
        batch(vecs[4]);
        idle(2);
        chk("pre_reset_out_valid", int'(out_valid), 1);
        chk("pre_reset_out_n", int'(out_n), 1368);
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("strobe_rst_out_valid", int'(out_valid), 0);
        chk("strobe_rst_out_n", int'(out_n), 0);
        idle(2);
        rst_n = 1'b1;
        batch(vecs[1]);
        idle(6);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
